// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and game-key decoder: turns make/break scan codes
// (with E0/F0 prefixes) into held levels for left, right and jump.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   prev_clk;
    logic                   clk_s, data_s, fall;
    logic [2:0]             bit_cnt, bit_cnt_d;
    logic [7:0]             shift, shift_d;
    logic                   par, par_d;
    logic [TW-1:0]          timer, timer_d;
    logic                   accept, err;
    logic                   ext, brk;
    logic [8:0]             key;
    logic                   hit_left, hit_right, hit_jump;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = prev_clk & ~clk_s;

    // Loaded with 1 so that reset looks like an idle line and creates no fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            prev_clk  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_clk  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            par     <= par_d;
            timer   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_d     = par;
        timer_d   = '0;
        accept    = 1'b0;
        err       = 1'b0;

        if (state != IDLE)
            timer_d = fall ? '0 : timer + TW'(1);

        case (state)
            IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && (^{shift, par}))
                        accept = 1'b1;
                    else
                        err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stalled partial frame: abandon it so the next start bit is recognised.
        if (state != IDLE && !fall && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err     = 1'b1;
            timer_d = '0;
        end
    end

    assign key       = {ext, shift};
    assign hit_left  = (key == 9'h16B) || (key == 9'h01C);
    assign hit_right = (key == 9'h174) || (key == 9'h023);
    assign hit_jump  = (key == 9'h029) || (key == 9'h01D) || (key == 9'h175);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            left       <= 1'b0;
            right      <= 1'b0;
            jump       <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= err;
            if (accept) begin
                code <= shift;
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    if (hit_left)  left  <= ~brk;
                    if (hit_right) right <= ~brk;
                    if (hit_jump)  jump  <= ~brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end else if (err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule
